// File: rtl/triangle_fetch.sv
// Pops one packed triangle from the vertices FIFO, sorts its vertices by Y with a
// three-step compare-swap network and hands the result to setup over valid/ready.
module triangle_fetch #(
  parameter int VW    = 38,
  parameter int CW    = 8,
  parameter int Y_LSB = 10,
  parameter int Y_W   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CW+3*VW-1:0]   vertices_rddata,
  output logic                 vertices_pop,
  input  logic                 vertices_empty,
  output logic                 tri_valid,
  input  logic                 tri_ready,
  output logic [CW-1:0]        tri_cmd,
  output logic [VW-1:0]        tri_v0,
  output logic [VW-1:0]        tri_v1,
  output logic [VW-1:0]        tri_v2,
  output logic                 tri_flip
);

  localparam int EW = CW + 3 * VW;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPT,
    S0,
    S1,
    S2,
    OUT
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic            pop_reg;
  logic [CW-1:0]   cmd_reg;
  logic [VW-1:0]   vtx_reg [3];
  logic            flip_reg;
  logic [Y_W-1:0]  y [3];
  logic            swap_ab;
  logic            swap_bc;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_y
      assign y[gi] = vtx_reg[gi][Y_LSB +: Y_W];
    end
  endgenerate

  // Strict compare keeps equal-Y vertices in FIFO order.
  assign swap_ab = ((state_reg == S0) || (state_reg == S2)) && (y[0] > y[1]);
  assign swap_bc = (state_reg == S1) && (y[1] > y[2]);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (!vertices_empty) state_next = POP;
      POP:  state_next = CAPT;
      CAPT: state_next = (vertices_rddata[EW-1 -: CW] == '0) ? IDLE : S0;
      S0:   state_next = S1;
      S1:   state_next = S2;
      S2:   state_next = OUT;
      OUT: begin
        if (tri_ready) state_next = vertices_empty ? IDLE : POP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pop_reg   <= 1'b0;
      cmd_reg   <= '0;
      flip_reg  <= 1'b0;
      for (int i = 0; i < 3; i++) vtx_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      // Pop strobe is registered so it is high exactly while in POP.
      pop_reg   <= (state_next == POP);
      if (state_reg == CAPT) begin
        cmd_reg    <= vertices_rddata[EW-1 -: CW];
        vtx_reg[0] <= vertices_rddata[3*VW-1 -: VW];
        vtx_reg[1] <= vertices_rddata[2*VW-1 -: VW];
        vtx_reg[2] <= vertices_rddata[VW-1 -: VW];
        flip_reg   <= 1'b0;
      end else if (swap_ab) begin
        vtx_reg[0] <= vtx_reg[1];
        vtx_reg[1] <= vtx_reg[0];
        flip_reg   <= ~flip_reg;
      end else if (swap_bc) begin
        vtx_reg[1] <= vtx_reg[2];
        vtx_reg[2] <= vtx_reg[1];
        flip_reg   <= ~flip_reg;
      end
    end
  end

  assign vertices_pop = pop_reg;
  assign tri_valid    = (state_reg == OUT);
  assign tri_cmd      = cmd_reg;
  assign tri_v0       = vtx_reg[0];
  assign tri_v1       = vtx_reg[1];
  assign tri_v2       = vtx_reg[2];
  assign tri_flip     = flip_reg;

endmodule

// File: tb/tb_triangle_fetch.sv
// Scoreboard bench for triangle_fetch: a queue-backed FIFO model feeds the DUT and
// a stable-sort reference predicts each emitted triangle.
module tb_triangle_fetch;

  localparam int VW = 38;
  localparam int CW = 8;
  localparam int EW = CW + 3 * VW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [EW-1:0] vertices_rddata = '0;
  logic          vertices_pop;
  logic          vertices_empty;
  logic          tri_valid;
  logic          tri_ready = 1'b0;
  logic [CW-1:0] tri_cmd;
  logic [VW-1:0] tri_v0, tri_v1, tri_v2;
  logic          tri_flip;

  always #5 clk = ~clk;

  triangle_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .vertices_rddata (vertices_rddata),
    .vertices_pop    (vertices_pop),
    .vertices_empty  (vertices_empty),
    .tri_valid       (tri_valid),
    .tri_ready       (tri_ready),
    .tri_cmd         (tri_cmd),
    .tri_v0          (tri_v0),
    .tri_v1          (tri_v1),
    .tri_v2          (tri_v2),
    .tri_flip        (tri_flip)
  );

  typedef struct {
    logic [CW-1:0] cmd;
    logic [VW-1:0] v0, v1, v2;
    logic          flip;
  } exp_t;

  logic [EW-1:0] fifo[$];
  exp_t          exp_q[$];
  int vec_cnt = 0, err_cnt = 0;
  int cyc = 0, pops = 0, pushes = 0, pop_cyc = 0;

  assign vertices_empty = (fifo.size() == 0);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkv(input logic [9:0] yv);
    logic [VW-1:0] v;
    v = {$urandom, $urandom};
    v[19:10] = yv;
    return v;
  endfunction

  // Reference: stable ascending sort by rank, parity from inversion count.
  task automatic push(input logic [7:0] cmd, input logic [9:0] ya, input logic [9:0] yb,
                      input logic [9:0] yc);
    logic [VW-1:0] v [3];
    logic [9:0]    yy [3];
    int            rank [3];
    logic [VW-1:0] o [3];
    int            inv;
    exp_t          e;
    yy[0] = ya; yy[1] = yb; yy[2] = yc;
    for (int i = 0; i < 3; i++) v[i] = mkv(yy[i]);
    fifo.push_back({cmd, v[0], v[1], v[2]});
    pushes++;
    if (cmd != 8'h00) begin
      for (int i = 0; i < 3; i++) begin
        rank[i] = 0;
        for (int j = 0; j < 3; j++)
          if (yy[j] < yy[i] || (yy[j] == yy[i] && j < i)) rank[i]++;
      end
      for (int i = 0; i < 3; i++) o[rank[i]] = v[i];
      inv = 0;
      for (int i = 0; i < 3; i++)
        for (int j = i + 1; j < 3; j++)
          if (rank[i] > rank[j]) inv++;
      e.cmd = cmd; e.v0 = o[0]; e.v1 = o[1]; e.v2 = o[2]; e.flip = inv[0];
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: read data appears mid-cycle of the pop and holds until the next pop.
  always @(negedge clk) begin
    if (rst_n && vertices_pop) begin
      if (fifo.size() == 0) check("pop_while_empty", 1, 0);
      else begin
        vertices_rddata = fifo.pop_front();
        pops++;
        pop_cyc = cyc;
      end
    end
  end

  logic          prev_valid = 1'b0, prev_ready = 1'b0;
  logic [122:0]  held = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (tri_valid && !prev_valid) check("latency", cyc - pop_cyc, 5);
      if (tri_valid) check("pop_in_out", vertices_pop, 0);
      if (tri_valid && prev_valid && !prev_ready)
        check("stall_stable", {tri_cmd, tri_v0, tri_v1, tri_v2, tri_flip}, held);
      if (tri_valid && tri_ready) begin
        if (exp_q.size() == 0) check("unexpected_tri", 1, 0);
        else begin
          e = exp_q.pop_front();
          $display("tri cmd=%02h v0=%010h v1=%010h v2=%010h flip=%0d", tri_cmd, tri_v0,
                   tri_v1, tri_v2, tri_flip);
          check("cmd", tri_cmd, e.cmd);
          check("v0", tri_v0, e.v0);
          check("v1", tri_v1, e.v1);
          check("v2", tri_v2, e.v2);
          check("flip", tri_flip, e.flip);
        end
      end
      prev_valid = tri_valid;
      prev_ready = tri_ready;
      held = {tri_cmd, tri_v0, tri_v1, tri_v2, tri_flip};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || !vertices_empty); i++) tick();
    repeat (8) tick();
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!tri_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, tri_valid, 1);
  endtask

  initial begin
    int p0;
    // Reset values
    repeat (3) tick();
    check("rst_valid", tri_valid, 0);
    check("rst_pop", vertices_pop, 0);
    check("rst_outs", {tri_cmd, tri_v0, tri_v1, tri_v2, tri_flip}, 0);
    rst_n = 1'b1;
    tick();

    // Reset while presenting a triangle
    tri_ready = 1'b0;
    push(8'h07, 10'd8, 10'd2, 10'd5);
    wait_valid("rst_test_reach_out");
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", tri_valid, 0);
    check("midrst_pop", vertices_pop, 0);
    check("midrst_outs", {tri_cmd, tri_v0, tri_v1, tri_v2, tri_flip}, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("midrst_idle", tri_valid, 0);

    // Basic sorts, reversal, pre-sorted, ties
    tri_ready = 1'b1;
    p0 = pops;
    push(8'h01, 10'd5, 10'd3, 10'd9);
    drain();
    check("single_pop", pops - p0, 1);
    push(8'h02, 10'd9, 10'd5, 10'd1);
    push(8'h02, 10'd1, 10'd5, 10'd9);
    push(8'h04, 10'd4, 10'd4, 10'd2);
    push(8'hff, 10'd1023, 10'd0, 10'd1023);
    drain();

    // NOP entry dropped
    p0 = pops;
    push(8'h00, 10'd1, 10'd2, 10'd3);
    push(8'h03, 10'd7, 10'd6, 10'd5);
    drain();
    check("nop_pops", pops - p0, 2);

    // Back-pressure with three queued entries
    tri_ready = 1'b0;
    p0 = pops;
    push(8'h11, 10'd30, 10'd20, 10'd10);
    push(8'h12, 10'd3, 10'd1, 10'd2);
    push(8'h13, 10'd6, 10'd6, 10'd6);
    wait_valid("bp_reach_out");
    repeat (10) tick();
    check("bp_stall_pops", pops - p0, 1);
    tri_ready = 1'b1;
    drain();
    check("bp_total_pops", pops - p0, 3);

    // Random mix with NOPs, ties and random back-pressure
    for (int k = 0; k < 20; k++)
      push(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
           10'($urandom_range(0, 7)), 10'($urandom_range(0, 7)), 10'($urandom_range(0, 7)));
    for (int i = 0; i < 2000 && (exp_q.size() != 0 || !vertices_empty); i++) begin
      tri_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    tri_ready = 1'b1;
    drain();
    check("total_pops", pops, pushes);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
